// File: rtl/wb_dual_retire.sv
// Write-back end of the dual-lane pipeline: retires one issued bundle through the single
// regfile write port in program order (top, then bottom), with overflow redirected to r30.
module wb_dual_retire #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      insn_top,
   input  logic [31:0]      data_top,
   input  logic             ovf_top,
   input  logic [31:0]      insn_bot,
   input  logic [31:0]      data_bot,
   input  logic             ovf_bot,
   output logic             wb_we,
   output logic [4:0]       wb_rd,
   output logic [31:0]      wb_data,
   output logic [CNT_W-1:0] retire_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, WR_TOP = 2'd1, WR_BOT = 2'd2} state_t;
   typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_TOP = 2'd1, SEL_BOT = 2'd2, SEL_PEND = 2'd3} sel_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } lane_t;

   // Status code written to r30 when an arithmetic op overflows; 0 means ovf is ignored.
   function automatic logic [31:0] ovf_code(input logic [31:0] insn);
      logic [31:0] code;
      code = 32'd0;
      case (insn[31:27])
         5'b00101: code = 32'd2;
         5'b00000: begin
            case (insn[6:2])
               5'd0:    code = 32'd1;
               5'd1:    code = 32'd3;
               5'd6:    code = 32'd4;
               5'd7:    code = 32'd5;
               default: code = 32'd0;
            endcase
         end
         default: code = 32'd0;
      endcase
      return code;
   endfunction

   function automatic lane_t decode(input logic [31:0] insn, input logic [31:0] data,
                                    input logic ovf);
      lane_t       l;
      logic [31:0] code;
      l.we   = 1'b0;
      l.rd   = insn[26:22];
      l.data = data;
      code   = ovf_code(insn);
      if (insn != 32'd0) begin
         case (insn[31:27])
            5'b00000, 5'b00101, 5'b01000: l.we = 1'b1;
            5'b00011: begin
               l.we = 1'b1;
               l.rd = 5'd31;
            end
            5'b10101: begin
               l.we = 1'b1;
               l.rd = 5'd30;
            end
            default: l.we = 1'b0;
         endcase
      end else begin
         l.we = 1'b0;
      end
      if (l.we && ovf && (code != 32'd0)) begin
         l.rd   = 5'd30;
         l.data = code;
      end else begin
         l.rd   = l.rd;
      end
      if (l.rd == 5'd0) begin
         l.we = 1'b0;
      end else begin
         l.we = l.we;
      end
      return l;
   endfunction

   state_t           state_r, state_nxt_s;
   sel_t             sel_s;
   lane_t            top_s, bot_s, pend_r;
   logic             top_we_s, accept_s;
   logic [CNT_W-1:0] nb_s;

   assign top_s    = decode(insn_top, data_top, ovf_top);
   assign bot_s    = decode(insn_bot, data_bot, ovf_bot);
   // Same destination in both lanes: the younger (bottom) write is the only one that matters.
   assign top_we_s = top_s.we && !(bot_s.we && (top_s.rd == bot_s.rd));
   assign nb_s     = CNT_W'(insn_top != 32'd0) + CNT_W'(insn_bot != 32'd0);
   assign in_ready = !reset && ((state_r == IDLE) || (state_r == WR_BOT) ||
                                ((state_r == WR_TOP) && !pend_r.we));
   assign accept_s = in_valid && in_ready;

   // Next state and which write source loads the output registers.
   always_comb begin
      state_nxt_s = IDLE;
      sel_s       = SEL_NONE;
      if ((state_r == WR_TOP) && pend_r.we) begin
         state_nxt_s = WR_BOT;
         sel_s       = SEL_PEND;
      end else if (accept_s) begin
         if (top_we_s) begin
            state_nxt_s = WR_TOP;
            sel_s       = SEL_TOP;
         end else if (bot_s.we) begin
            state_nxt_s = WR_BOT;
            sel_s       = SEL_BOT;
         end else begin
            state_nxt_s = IDLE;
            sel_s       = SEL_NONE;
         end
      end else begin
         state_nxt_s = IDLE;
         sel_s       = SEL_NONE;
      end
   end

   // State, pending bottom write, registered write port and retire counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         pend_r     <= '0;
         wb_we      <= 1'b0;
         wb_rd      <= 5'd0;
         wb_data    <= 32'd0;
         retire_cnt <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         wb_we   <= (state_nxt_s != IDLE);
         case (sel_s)
            SEL_TOP: begin
               wb_rd   <= top_s.rd;
               wb_data <= top_s.data;
            end
            SEL_BOT: begin
               wb_rd   <= bot_s.rd;
               wb_data <= bot_s.data;
            end
            SEL_PEND: begin
               wb_rd   <= pend_r.rd;
               wb_data <= pend_r.data;
            end
            default: begin
               wb_rd   <= wb_rd;
               wb_data <= wb_data;
            end
         endcase
         if (accept_s) begin
            pend_r     <= bot_s;
            retire_cnt <= retire_cnt + nb_s;
         end else begin
            pend_r     <= pend_r;
            retire_cnt <= retire_cnt;
         end
      end
   end

endmodule

// File: tb/tb_wb_dual_retire.sv
// Bench for wb_dual_retire: directed scenarios then random bundles, checked against a
// queue-of-pending-writes model of the retire port.
module tb_wb_dual_retire;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, in_valid, in_ready;
   logic [31:0]   insn_top, data_top, insn_bot, data_bot;
   logic          ovf_top, ovf_bot;
   logic          wb_we;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_data;
   logic [CW-1:0] retire_cnt;

   always #5 clk = ~clk;

   wb_dual_retire #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .insn_top(insn_top), .data_top(data_top), .ovf_top(ovf_top),
      .insn_bot(insn_bot), .data_bot(data_bot), .ovf_bot(ovf_bot),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .retire_cnt(retire_cnt)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   int          vectors = 0;
   int          errors  = 0;
   wr_t         q[$];
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   int          m_cnt;

   function automatic logic [31:0] mk(input int op, input int rd, input int alu);
      logic [31:0] v;
      v        = 32'd0;
      v[31:27] = op[4:0];
      v[26:22] = rd[4:0];
      v[6:2]   = alu[4:0];
      return v;
   endfunction

   // Architectural effect of one lane: does it write, where, and what.
   function automatic void model_lane(input logic [31:0] insn, input logic [31:0] d,
                                      input logic ovf, output bit w, output int rd,
                                      output logic [31:0] v);
      int op, alu, code;
      op   = int'(insn[31:27]);
      alu  = int'(insn[6:2]);
      rd   = int'(insn[26:22]);
      v    = d;
      w    = 1'b0;
      code = 0;
      if (insn == 32'd0) return;
      if (op == 0 || op == 5 || op == 8) w = 1'b1;
      else if (op == 3) begin w = 1'b1; rd = 31; end
      else if (op == 21) begin w = 1'b1; rd = 30; end
      if (w && ovf) begin
         if (op == 5) code = 2;
         else if (op == 0) code = (alu == 0) ? 1 : (alu == 1) ? 3 : (alu == 6) ? 4 : (alu == 7) ? 5 : 0;
         if (code != 0) begin rd = 30; v = 32'(code); end
      end
      if (rd == 0) w = 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check in_ready, update model at posedge, check outputs.
   task automatic cycle(input logic rst, input logic v,
                        input logic [31:0] it, input logic [31:0] dt, input logic ot,
                        input logic [31:0] ib, input logic [31:0] db, input logic ob);
      bit          exp_rdy, acc, wt, wbt;
      int          rt, rb;
      logic [31:0] vt, vb;
      wr_t         e;
      reset = rst; in_valid = v;
      insn_top = it; data_top = dt; ovf_top = ot;
      insn_bot = ib; data_bot = db; ovf_bot = ob;
      #1;
      exp_rdy = !rst && (q.size() == 0);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      acc = v && exp_rdy;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_cnt = 0;
      end else begin
         if (acc) begin
            model_lane(it, dt, ot, wt, rt, vt);
            model_lane(ib, db, ob, wbt, rb, vb);
            if (wt && wbt && rt == rb) wt = 1'b0;
            if (wt) begin e.rd = rt[4:0]; e.data = vt; q.push_back(e); end
            if (wbt) begin e.rd = rb[4:0]; e.data = vb; q.push_back(e); end
            m_cnt = (m_cnt + int'(it != 32'd0) + int'(ib != 32'd0)) % (1 << CW);
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            m_we = 1'b1; m_rd = e.rd; m_data = e.data;
         end else begin
            m_we = 1'b0;
         end
      end
      #1;
      chk("wb_we", {31'd0, wb_we}, {31'd0, m_we});
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
      chk("wb_data", wb_data, m_data);
      chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
      @(negedge clk);
   endtask

   function automatic logic [31:0] rnd_insn();
      int ops[6];
      int alus[5];
      ops  = '{0, 5, 8, 3, 21, 12};
      alus = '{0, 1, 6, 7, 2};
      if ($urandom_range(0, 5) == 0) return 32'd0;
      return mk(ops[$urandom_range(0, 5)], int'($urandom_range(0, 4)), alus[$urandom_range(0, 4)]);
   endfunction

   initial begin
      reset = 1'b1; in_valid = 1'b0;
      insn_top = 32'd0; data_top = 32'd0; ovf_top = 1'b0;
      insn_bot = 32'd0; data_bot = 32'd0; ovf_bot = 1'b0;
      m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_cnt = 0;
      @(negedge clk);
      cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      cycle(1'b1, 1'b1, mk(5, 3, 0), 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      // addi r3=7 with bottom bubble
      cycle(1'b0, 1'b1, mk(5, 3, 0), 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      // add r1=5, lw r2=9: two write cycles
      cycle(1'b0, 1'b1, mk(0, 1, 0), 32'd5, 1'b0, mk(8, 2, 0), 32'd9, 1'b0);
      cycle(1'b0, 1'b1, mk(5, 6, 0), 32'd66, 1'b0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      // add ovf and sub ovf both target r30: one write, code 3
      cycle(1'b0, 1'b1, mk(0, 4, 0), 32'd11, 1'b1, mk(0, 4, 1), 32'd12, 1'b1);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      // jal to r31, bottom targets r0
      cycle(1'b0, 1'b1, mk(3, 9, 0), 32'h40, 1'b0, mk(5, 0, 0), 32'h55, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      // two-write bundle interrupted by reset before its second write
      cycle(1'b0, 1'b1, mk(0, 1, 0), 32'd5, 1'b0, mk(8, 2, 0), 32'd9, 1'b0);
      cycle(1'b1, 1'b1, mk(5, 7, 0), 32'd8, 1'b0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      // back-to-back single-write bundles, then two-lane bundles across the counter wrap
      for (int i = 0; i < 6; i++)
         cycle(1'b0, 1'b1, mk(5, i + 1, 0), 32'(i + 100), 1'b0, 32'd0, 32'd0, 1'b0);
      for (int i = 0; i < 12; i++)
         cycle(1'b0, 1'b1, mk(12, 1, 0), 32'd1, 1'b0, mk(5, i + 1, 0), 32'(i), 1'b0);
      // random traffic with occasional resets
      for (int i = 0; i < 500; i++)
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
               rnd_insn(), $urandom, 1'($urandom_range(0, 1)),
               rnd_insn(), $urandom, 1'($urandom_range(0, 1)));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
